// File: rtl/bus_pkg.sv
// Shared definitions for the PHI0-phase bus timing blocks.
//   bus_state_t      : wait-state controller states (IDLE, STRETCH, HOLDOFF)
//   DEF_WAIT_STATES  : default number of extra PHI2 cycles per slow access
//   DEF_WE_DELAY     : default write-strobe setup delay in CLK_SRC cycles
package bus_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_STRETCH = 2'd1,
    ST_HOLDOFF = 2'd2
  } bus_state_t;

  localparam int DEF_WAIT_STATES = 2;
  localparam int DEF_WE_DELAY    = 1;

endpackage

// File: rtl/bus_wait_gen_phi_edge.sv
// phi_edge: registers the PHI0 phase clock and produces single-cycle
// rise/fall pulses in the CLK_SRC domain.
// Ports:
//   clk   in  CLK_SRC
//   rst   in  asynchronous active-high reset
//   phi0  in  PHI0, already synchronous to clk
//   rise  out one-cycle pulse on the first clk cycle PHI0 is seen high
//   fall  out one-cycle pulse on the first clk cycle PHI0 is seen low
module phi_edge (
  input  logic clk,
  input  logic rst,
  input  logic phi0,
  output logic rise,
  output logic fall
);

  logic phi0_q;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      phi0_q <= 1'b0;
    end else begin
      phi0_q <= phi0;
    end
  end

  assign rise = phi0 & ~phi0_q;
  assign fall = ~phi0 & phi0_q;

endmodule

// File: rtl/bus_wait_gen.sv
// bus_wait_gen: 6502 RDY wait-state generator and bus strobe timing.
// Stretches slow-device accesses by WAIT_STATES PHI2 cycles and produces
// registered OE_N/WE_N strobes qualified by the PHI2-high phase.
// Ports:
//   CLK_SRC   in  source clock (single domain)
//   RST       in  asynchronous active-high reset
//   PHI0      in  CPU phase clock, synchronous to CLK_SRC
//   CS_ANY    in  some device selected for the current address
//   SLOW_SEL  in  selected device needs wait states
//   RWB       in  CPU read/write (1 = read)
//   RDY       out CPU RDY; low stalls the current cycle
//   OE_N      out active-low read strobe
//   WE_N      out active-low write strobe
module bus_wait_gen
  import bus_pkg::*;
#(
  parameter int WAIT_STATES = DEF_WAIT_STATES,
  parameter int WE_DELAY    = DEF_WE_DELAY,
  parameter int CNT_W       = 4
) (
  input  logic CLK_SRC,
  input  logic RST,
  input  logic PHI0,
  input  logic CS_ANY,
  input  logic SLOW_SEL,
  input  logic RWB,
  output logic RDY,
  output logic OE_N,
  output logic WE_N
);

  localparam logic [CNT_W-1:0] WAIT_INIT = CNT_W'(WAIT_STATES);
  localparam logic [CNT_W-1:0] WE_THR    = CNT_W'(WE_DELAY);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);
  localparam logic [CNT_W-1:0] CNT_MAX   = {CNT_W{1'b1}};
  localparam bit               STRETCH_EN = (WAIT_STATES > 0);

  bus_state_t       state;
  logic [CNT_W-1:0] wait_cnt;
  logic [CNT_W-1:0] we_cnt;
  logic             final_cyc;
  logic             rise;
  logic             fall;
  logic             we_ok;

  phi_edge u_phi_edge (
    .clk  (CLK_SRC),
    .rst  (RST),
    .phi0 (PHI0),
    .rise (rise),
    .fall (fall)
  );

  // Wait-state controller. final_cyc marks the PHI2 cycle in which the
  // access actually completes; only that cycle may carry a write strobe.
  always_ff @(posedge CLK_SRC or posedge RST) begin
    if (RST) begin
      state     <= ST_IDLE;
      wait_cnt  <= '0;
      final_cyc <= 1'b0;
      RDY       <= 1'b1;
    end else begin
      if (fall) begin
        final_cyc <= 1'b0;
      end
      case (state)
        ST_IDLE: begin
          if (rise) begin
            if (SLOW_SEL && STRETCH_EN) begin
              RDY       <= 1'b0;
              wait_cnt  <= WAIT_INIT;
              final_cyc <= 1'b0;
              state     <= ST_STRETCH;
            end else begin
              final_cyc <= 1'b1;
            end
          end
        end
        ST_STRETCH: begin
          // Decoder inputs are deliberately ignored here: once a stretch
          // starts it always runs its full length.
          if (fall) begin
            wait_cnt <= wait_cnt - CNT_ONE;
            if (wait_cnt == CNT_ONE) begin
              // Released right after the last stalled fall, so RDY is
              // stable high long before the completing cycle's fall.
              RDY   <= 1'b1;
              state <= ST_HOLDOFF;
            end
          end
        end
        ST_HOLDOFF: begin
          // This rise belongs to the stalled access itself; never re-arm.
          if (rise) begin
            final_cyc <= 1'b1;
            state     <= ST_IDLE;
          end
        end
        default: begin
          state <= ST_IDLE;
        end
      endcase
    end
  end

  assign we_ok = (we_cnt >= WE_THR);

  // Strobe timing: we_cnt measures CLK_SRC cycles since the PHI0 rise to
  // give address/data setup before WE_N falls.
  always_ff @(posedge CLK_SRC or posedge RST) begin
    if (RST) begin
      we_cnt <= '0;
      OE_N   <= 1'b1;
      WE_N   <= 1'b1;
    end else begin
      if (rise) begin
        we_cnt <= '0;
      end else if (PHI0 && (we_cnt != CNT_MAX)) begin
        we_cnt <= we_cnt + CNT_ONE;
      end
      OE_N <= ~(PHI0 & RWB & CS_ANY);
      WE_N <= ~(PHI0 & ~RWB & CS_ANY & final_cyc & we_ok & (state == ST_IDLE));
    end
  end

endmodule

// File: tb/tb_bus_wait_gen.sv
// Directed bench for bus_wait_gen. PHI0 is driven as a divide-by-8 clock
// (4 CLK_SRC cycles high, 4 low). Each half phase samples the outputs
// 1 time unit after each of its 4 clock edges and packs them MSB-first.
// dut uses WAIT_STATES=2, dut0 uses WAIT_STATES=0 with the same inputs.
module tb_bus_wait_gen;

  logic clk = 1'b0;
  logic rst;
  logic phi0;
  logic cs_any;
  logic slow_sel;
  logic rwb;
  logic rdy, oe_n, we_n;
  logic rdy0, oe_n0, we_n0;

  int checks = 0;
  int errors = 0;

  logic [3:0] rdy_v, oe_v, we_v, rdy0_v, we0_v;

  always #10 clk = ~clk;

  bus_wait_gen #(.WAIT_STATES(2), .WE_DELAY(1), .CNT_W(4)) dut (
    .CLK_SRC (clk),
    .RST     (rst),
    .PHI0    (phi0),
    .CS_ANY  (cs_any),
    .SLOW_SEL(slow_sel),
    .RWB     (rwb),
    .RDY     (rdy),
    .OE_N    (oe_n),
    .WE_N    (we_n)
  );

  bus_wait_gen #(.WAIT_STATES(0), .WE_DELAY(1), .CNT_W(4)) dut0 (
    .CLK_SRC (clk),
    .RST     (rst),
    .PHI0    (phi0),
    .CS_ANY  (cs_any),
    .SLOW_SEL(slow_sel),
    .RWB     (rwb),
    .RDY     (rdy0),
    .OE_N    (oe_n0),
    .WE_N    (we_n0)
  );

  task automatic chk(input string tag, input logic [3:0] obs, input logic [3:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s observed=%b expected=%b", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #1;
  endtask

  task automatic half(input logic lvl);
    phi0 = lvl;
    for (int j = 0; j < 4; j++) begin
      step();
      rdy_v[3-j]  = rdy;
      oe_v[3-j]   = oe_n;
      we_v[3-j]   = we_n;
      rdy0_v[3-j] = rdy0;
      we0_v[3-j]  = we_n0;
    end
  endtask

  initial begin
    rst = 1'b0; phi0 = 1'b0; cs_any = 1'b0; slow_sel = 1'b0; rwb = 1'b1;
    #5 rst = 1'b1;
    step();
    chk("reset_outs",  {1'b0, rdy,  oe_n,  we_n},  4'b0111);
    chk("reset_outs0", {1'b0, rdy0, oe_n0, we_n0}, 4'b0111);
    step();
    rst = 1'b0;
    half(1'b0);

    // Fast read
    cs_any = 1'b1; slow_sel = 1'b0; rwb = 1'b1;
    half(1'b1);
    chk("fast_rd_rdy_hi", rdy_v, 4'b1111);
    chk("fast_rd_oe_hi",  oe_v,  4'b0000);
    chk("fast_rd_we_hi",  we_v,  4'b1111);
    half(1'b0);
    chk("fast_rd_oe_lo",  oe_v,  4'b1111);
    chk("fast_rd_rdy_lo", rdy_v, 4'b1111);

    // Slow write, 2 wait states
    slow_sel = 1'b1; rwb = 1'b0;
    half(1'b1);
    chk("sw_h1_rdy",  rdy_v,  4'b0000);
    chk("sw_h1_we",   we_v,   4'b1111);
    chk("sw_h1_oe",   oe_v,   4'b1111);
    chk("ws0_h1_rdy", rdy0_v, 4'b1111);
    chk("ws0_h1_we",  we0_v,  4'b1100);
    half(1'b0);
    chk("sw_l1_rdy",  rdy_v,  4'b0000);
    chk("sw_l1_we",   we_v,   4'b1111);
    slow_sel = 1'b0;  // must not shorten the stretch
    half(1'b1);
    chk("sw_h2_rdy",  rdy_v,  4'b0000);
    chk("sw_h2_we",   we_v,   4'b1111);
    chk("ws0_h2_we",  we0_v,  4'b1100);
    half(1'b0);
    chk("sw_l2_rdy",  rdy_v,  4'b1111);
    slow_sel = 1'b1;  // completing cycle must not re-arm
    half(1'b1);
    chk("sw_h3_rdy",  rdy_v,  4'b1111);
    chk("sw_h3_we",   we_v,   4'b1100);
    half(1'b0);
    chk("sw_l3_we",   we_v,   4'b1111);
    chk("sw_l3_rdy",  rdy_v,  4'b1111);

    // Back-to-back slow reads
    rwb = 1'b1; slow_sel = 1'b1;
    half(1'b1); chk("bb_h1_rdy", rdy_v, 4'b0000); chk("bb_h1_oe", oe_v, 4'b0000);
    half(1'b0); chk("bb_l1_rdy", rdy_v, 4'b0000);
    half(1'b1); chk("bb_h2_rdy", rdy_v, 4'b0000); chk("bb_h2_oe", oe_v, 4'b0000);
    half(1'b0); chk("bb_l2_rdy", rdy_v, 4'b1111);
    half(1'b1); chk("bb_h3_rdy", rdy_v, 4'b1111);
    half(1'b0); chk("bb_l3_rdy", rdy_v, 4'b1111);
    half(1'b1); chk("bb_h4_rdy", rdy_v, 4'b0000);
    half(1'b0); chk("bb_l4_rdy", rdy_v, 4'b0000);
    half(1'b1); chk("bb_h5_rdy", rdy_v, 4'b0000);
    half(1'b0); chk("bb_l5_rdy", rdy_v, 4'b1111);
    half(1'b1); chk("bb_h6_rdy", rdy_v, 4'b1111);
    half(1'b0);

    // Reset in the middle of a stretch (wait_cnt = 1)
    half(1'b1); chk("rs_h1_rdy", rdy_v, 4'b0000);
    half(1'b0); chk("rs_l1_rdy", rdy_v, 4'b0000);
    phi0 = 1'b1;
    step();
    step();
    chk("rs_pre_rst", {1'b0, rdy, oe_n, we_n}, 4'b0001);
    rst = 1'b1;
    #1;
    chk("rs_async", {1'b0, rdy, oe_n, we_n}, 4'b0111);
    step();
    step();
    phi0 = 1'b0;
    step();
    chk("rs_held", {1'b0, rdy, oe_n, we_n}, 4'b0111);
    rst = 1'b0;
    half(1'b0);
    half(1'b1); chk("rs_h2_rdy", rdy_v, 4'b0000);
    half(1'b0); chk("rs_l2_rdy", rdy_v, 4'b0000);
    half(1'b1); chk("rs_h3_rdy", rdy_v, 4'b0000);
    half(1'b0); chk("rs_l3_rdy", rdy_v, 4'b1111);
    half(1'b1); chk("rs_h4_rdy", rdy_v, 4'b1111);
    half(1'b0);

    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
